// File: rtl/bench_ctrl_pkg.sv
// Shared types and default constants for the bench run controller.
// Optional milestone feature: BENCH_RUN_CTRL_MILESTONE_EN.
package bench_ctrl_pkg;

  localparam int CNT_W_DEF        = 20;
  localparam int DEF_LIMIT_DEF    = 1_000_000;
  localparam int DEF_INTERVAL_DEF = 200_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/milestone_tick.sv
// Phase counter that emits a one-cycle registered pulse each time a full
// interval of increments has elapsed. Used only with BENCH_RUN_CTRL_MILESTONE_EN.
module milestone_tick #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] ivl,
  output logic             pulse
);

  logic [CNT_W-1:0] phase_q, phase_d;
  logic             pulse_q, pulse_d;

  // Next phase and pulse: wrap to zero exactly when the interval completes
  always_comb begin
    phase_d = phase_q;
    pulse_d = 1'b0;
    if (clear) begin
      phase_d = {CNT_W{1'b0}};
    end else if (enable) begin
      if (phase_q + {{(CNT_W-1){1'b0}}, 1'b1} == ivl) begin
        phase_d = {CNT_W{1'b0}};
        pulse_d = 1'b1;
      end else begin
        phase_d = phase_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // Phase and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= {CNT_W{1'b0}};
      pulse_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/bench_run_ctrl.sv
// Run controller: counts to a latched limit with pause/abort and optional
// interval milestones (enabled by defining BENCH_RUN_CTRL_MILESTONE_EN).
module bench_run_ctrl
  import bench_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEF_LIMIT    = DEF_LIMIT_DEF,
  parameter int DEF_INTERVAL = DEF_INTERVAL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [CNT_W-1:0] limit,
  input  logic [CNT_W-1:0] interval,
  output logic             busy,
  output logic [CNT_W-1:0] cnt,
  output logic             milestone,
  output logic             done,
  output logic             aborted
);

  localparam logic [CNT_W-1:0] DEF_LIM_C = CNT_W'(DEF_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic             aborted_q, aborted_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             inc_s;
  logic             clr_s;
`ifdef BENCH_RUN_CTRL_MILESTONE_EN
  localparam logic [CNT_W-1:0] DEF_IVL_C = CNT_W'(DEF_INTERVAL);
  logic [CNT_W-1:0] ivl_q, ivl_d;
`endif

  // Next-state logic; busy/done are derived from the next state so they
  // change on the same edge as the state itself
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lim_d     = lim_q;
    aborted_d = aborted_q;
    inc_s     = 1'b0;
    clr_s     = 1'b0;
`ifdef BENCH_RUN_CTRL_MILESTONE_EN
    ivl_d     = ivl_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lim_d     = (limit == {CNT_W{1'b0}}) ? DEF_LIM_C : limit;
`ifdef BENCH_RUN_CTRL_MILESTONE_EN
          ivl_d     = (interval == {CNT_W{1'b0}}) ? DEF_IVL_C : interval;
`endif
          cnt_d     = {CNT_W{1'b0}};
          aborted_d = 1'b0;
          clr_s     = 1'b1;
          state_d   = ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN, ST_PAUSE: begin
        // abort beats both pause and a terminal increment
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          inc_s   = 1'b1;
          cnt_d   = cnt_q + ONE_C;
          state_d = (cnt_d == lim_q) ? ST_DONE : ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    done_d = (state_d == ST_DONE);
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      lim_q     <= DEF_LIM_C;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BENCH_RUN_CTRL_MILESTONE_EN
      ivl_q     <= DEF_IVL_C;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lim_q     <= lim_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BENCH_RUN_CTRL_MILESTONE_EN
      ivl_q     <= ivl_d;
`endif
    end
  end

`ifdef BENCH_RUN_CTRL_MILESTONE_EN
  milestone_tick #(.CNT_W(CNT_W)) u_milestone_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (inc_s),
    .clear  (clr_s),
    .ivl    (ivl_q),
    .pulse  (milestone)
  );
`else
  logic unused_s;
  assign unused_s  = ^{interval, inc_s, clr_s};
  assign milestone = 1'b0;
`endif

  assign busy    = busy_q;
  assign cnt     = cnt_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_bench_run_ctrl.sv
// Self-checking bench for bench_run_ctrl: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_bench_run_ctrl;

  localparam int CNT_W  = 20;
  localparam int DEF_L  = 60;
  localparam int DEF_I  = 12;
`ifdef BENCH_RUN_CTRL_MILESTONE_EN
  localparam bit MS_EN = 1'b1;
`else
  localparam bit MS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, pause, abort;
  logic [CNT_W-1:0] limit, interval;
  logic             busy, milestone, done, aborted;
  logic [CNT_W-1:0] cnt;

  int checks = 0;
  int errors = 0;
  int ms_seen = 0;

  // Reference model state
  bit m_active, m_done, m_aborted, m_ms;
  int m_cnt, m_lim, m_ivl;

  bench_run_ctrl #(.CNT_W(CNT_W), .DEF_LIMIT(DEF_L), .DEF_INTERVAL(DEF_I)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
    .limit(limit), .interval(interval), .busy(busy), .cnt(cnt),
    .milestone(milestone), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_aborted = 0; m_ms = 0;
    m_cnt = 0; m_lim = DEF_L; m_ivl = DEF_I;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'(m_active));
    chk({tag, ".cnt"}, 32'(cnt), m_cnt);
    chk({tag, ".milestone"}, 32'(milestone), 32'(m_ms));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".aborted"}, 32'(aborted), 32'(m_aborted));
  endtask

  // One clock: drive inputs, advance the model by the behavioural rules, compare
  task automatic step(input bit s, input bit p, input bit a, input int lim, input int ivl);
    start = s; pause = p; abort = a;
    limit = CNT_W'(lim); interval = CNT_W'(ivl);
    @(posedge clk);
    #1;
    m_ms = 0;
    if (!m_active) begin
      if (s) begin
        m_lim = (lim == 0) ? DEF_L : lim;
        m_ivl = (ivl == 0) ? DEF_I : ivl;
        m_cnt = 0; m_aborted = 0; m_done = 0; m_active = 1;
      end
    end else if (a) begin
      m_active = 0; m_aborted = 1;
    end else if (!p) begin
      m_cnt++;
      if (MS_EN && (m_cnt % m_ivl == 0)) m_ms = 1;
      if (m_cnt == m_lim) begin
        m_active = 0; m_done = 1;
      end
    end
    if (milestone === 1'b1) ms_seen++;
    check_all("step");
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; pause = 0; abort = 0; limit = '0; interval = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Basic run: limit 10, interval 4
    step(1, 0, 0, 10, 4);
    ms_seen = 0;
    idle_steps(10);
    chk("run10.done", 32'(done), 32'd1);
    chk("run10.cnt", 32'(cnt), 32'd10);
    chk("run10.busy", 32'(busy), 32'd0);
    chk("run10.ms_count", ms_seen, MS_EN ? 2 : 0);

    // Pause for three cycles at cnt=5
    step(1, 0, 0, 12, 4);
    ms_seen = 0;
    idle_steps(5);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0);
      chk("pause.hold", 32'(cnt), 32'd5);
    end
    idle_steps(6);
    chk("pause.not_done", 32'(done), 32'd0);
    idle_steps(1);
    chk("pause.done", 32'(done), 32'd1);
    chk("pause.cnt", 32'(cnt), 32'd12);
    chk("pause.ms_count", ms_seen, MS_EN ? 3 : 0);

    // Abort at cnt=6, abort in IDLE ignored, restart clears aborted
    step(1, 0, 0, 10, 0);
    idle_steps(6);
    step(0, 0, 1, 0, 0);
    chk("abort.cnt", 32'(cnt), 32'd6);
    chk("abort.flag", 32'(aborted), 32'd1);
    chk("abort.done", 32'(done), 32'd0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 10, 0);
    chk("restart.aborted", 32'(aborted), 32'd0);
    chk("restart.cnt", 32'(cnt), 32'd0);

    // Abort coinciding with terminal increment
    idle_steps(9);
    step(0, 0, 1, 0, 0);
    chk("abort_term.cnt", 32'(cnt), 32'd9);
    chk("abort_term.done", 32'(done), 32'd0);

    // Defaults for limit/interval; start during RUN ignored
    step(1, 0, 0, 0, 0);
    ms_seen = 0;
    step(1, 0, 0, 3, 1);
    idle_steps(DEF_L - 1);
    chk("default.done", 32'(done), 32'd1);
    chk("default.cnt", 32'(cnt), DEF_L);
    chk("default.ms_count", ms_seen, MS_EN ? DEF_L / DEF_I : 0);

    // Start and abort together in DONE: start wins
    step(1, 0, 1, 5, 0);
    chk("done_start_abort.busy", 32'(busy), 32'd1);
    // Abort wins over pause
    step(0, 1, 1, 0, 0);
    chk("abort_pause.aborted", 32'(aborted), 32'd1);

    // Asynchronous reset mid-run, then stays idle until a new start
    step(1, 0, 0, 30, 7);
    idle_steps(8);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_steps(3);
    step(1, 0, 0, 5, 2);
    idle_steps(5);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(24) == 0,
           int'($urandom_range(20)), int'($urandom_range(6)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bench_run_ctrl.md
BENCH_RUN_CTRL -- requirements
Module: bench_run_ctrl

Interface
REQ-001 Parameter CNT_W, default 20: counter and limit width.
REQ-002 Parameter DEF_LIMIT, default 1_000_000: terminal count used when limit input is 0.
REQ-003 Parameter DEF_INTERVAL, default 200_000: milestone spacing used when interval input is 0.
REQ-004 Port clk  input  1: clock; all state changes on posedge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port start  input  1: run request, level-sampled each cycle.
REQ-007 Port pause  input  1: hold counting while high.
REQ-008 Port abort  input  1: terminate current run.
REQ-009 Port limit  input  CNT_W: terminal count, sampled on accepted start.
REQ-010 Port interval  input  CNT_W: milestone spacing, sampled on accepted start.
REQ-011 Port busy  output  1: high in RUN or PAUSE.
REQ-012 Port cnt  output  CNT_W: current count.
REQ-013 Port milestone  output  1: one-cycle pulse per completed interval.
REQ-014 Port done  output  1: high while in DONE.
REQ-015 Port aborted  output  1: last run ended by abort; sticky until next accepted start.

Function
REQ-016 FSM states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-017 start accepted only in IDLE or DONE; ignored in RUN/PAUSE.
REQ-018 Accepted start: latch lim = (limit==0 ? DEF_LIMIT : limit), ivl = (interval==0 ? DEF_INTERVAL : interval); cnt<=0, phase<=0, aborted<=0, next state RUN.
REQ-019 RUN with pause=0, abort=0: cnt<=cnt+1, phase advances; first increment in the cycle after start accepted.
REQ-020 RUN with pause=1: no increment that cycle, next state PAUSE; PAUSE holds cnt/phase; pause=0 in PAUSE returns to RUN, increments resume the following cycle.
REQ-021 Increment making cnt==lim: next state DONE; cnt holds at lim; done=1 from that same edge.
REQ-022 milestone=1 for exactly one cycle, registered on the same edge cnt becomes k*ivl (k>=1), including when that value equals lim.
REQ-023 ivl > lim: no milestone pulses in the run.
REQ-024 abort in RUN or PAUSE: no increment that cycle, next state IDLE, cnt retains value, aborted<=1; abort wins over pause and over a coinciding terminal increment.
REQ-025 abort in IDLE or DONE: ignored.
REQ-026 start and abort in same cycle in DONE: start accepted.
REQ-027 cnt never wraps; lim up to 2^CNT_W-1 reachable.
REQ-028 busy=1 exactly in RUN and PAUSE; done=1 exactly in DONE.

Reset
REQ-029 rst_n low: state IDLE, cnt=0, phase=0, lim=DEF_LIMIT, ivl=DEF_INTERVAL, busy=0, milestone=0, done=0, aborted=0, regardless of state.
REQ-030 rst_n deassertion mid-run: block idles until a new start.

Configuration
REQ-031 Macro BENCH_RUN_CTRL_MILESTONE_EN defined: phase counter and milestone logic present per REQ-022/023.
REQ-032 Macro undefined: phase counter omitted, milestone tied 0, interval input ignored; all other behaviour unchanged.

Structure
REQ-033 Package bench_ctrl_pkg holds state enum typedef and default constants for CNT_W, DEF_LIMIT, DEF_INTERVAL.
REQ-034 Sub-module milestone_tick holds phase counter and milestone pulse (enable, clear, ivl in; pulse out); instantiated only under the macro.

Verification (CNT_W=20, macro defined unless stated)
REQ-035 start, limit=10, interval=4 -> milestones at cnt=4 and 8, done=1 with cnt=10 after 10 increments, busy low from that edge.
REQ-036 limit=12, interval=4, pause high 3 cycles at cnt=5 -> cnt holds 5 for 3 cycles, milestones at 4/8/12, done at cnt=12 three cycles later than unpaused.
REQ-037 limit=10, abort at cnt=6 -> IDLE, cnt=6, aborted=1, done=0; next start clears aborted, cnt restarts at 0.
REQ-038 limit=0, interval=0 -> runs to 1_000_000 with 5 milestones, done then set; start in RUN ignored.
REQ-039 abort coinciding with terminal increment (cnt=9, limit=10) -> cnt=9, IDLE, aborted=1, no done.
REQ-040 Macro undefined, limit=8, interval=2 -> milestone never asserts, done at cnt=8.
